// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and FSM state types
package uart_pkg;

  localparam int BAUD_DIV_DEFAULT = 2604;
  localparam int FRAME_BITS       = 10;

  typedef enum logic {
    TX_IDLE         = 1'b0,
    TX_TRANSMITTING = 1'b1
  } tx_state_e;

  typedef enum logic {
    RX_IDLE      = 1'b0,
    RX_RECEIVING = 1'b1
  } rx_state_e;

endpackage

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 serial receiver with two-flop input synchronizer
module uart_rx
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  input  logic       clr_rdy,
  output logic [7:0] rx_data,
  output logic       rdy
);

  localparam int CW   = $clog2(BAUD_DIV);
  localparam int HALF = BAUD_DIV / 2;

  rx_state_e     state_q, state_d;
  logic          rx_meta_q, rx_sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    bit_q, bit_d;
  logic [8:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          rdy_q, rdy_d;
  logic          start, sample, last;

  assign start  = (state_q == RX_IDLE) && !rx_sync_q;
  assign sample = (state_q == RX_RECEIVING) && (cnt_q == '0);
  assign last   = sample && (bit_q == 4'(FRAME_BITS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= RX;
      rx_sync_q <= rx_meta_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RX_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RX_IDLE:      if (!rx_sync_q) state_d = RX_RECEIVING;
      RX_RECEIVING: if (last) state_d = RX_IDLE;
      default:      state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    rx_data = data_q;
    rdy     = rdy_q;
  end

  // Counter is a down-counter: half a period to mid start bit, then full periods.
  always_comb begin
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    if (start) begin
      cnt_d = CW'(HALF - 1);
      bit_d = '0;
    end else if (sample) begin
      cnt_d   = CW'(BAUD_DIV - 1);
      bit_d   = bit_q + 4'd1;
      shift_d = {rx_sync_q, shift_q[8:1]};
      if (last) data_d = shift_q[8:1];
    end else if (state_q == RX_RECEIVING) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  // A completing frame beats a simultaneous clr_rdy.
  always_comb begin
    rdy_d = rdy_q;
    if (clr_rdy || start) rdy_d = 1'b0;
    if (last) rdy_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      rdy_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      rdy_q   <= rdy_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1 serial transmitter
module uart_tx
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       TX,
  output logic       tx_done
);

  localparam int CW = $clog2(BAUD_DIV);

  tx_state_e     state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [3:0]    bit_q, bit_d;
  logic [8:0]    shift_q, shift_d;
  logic          done_q, done_d;
  logic          baud_end;
  logic          last_bit;

  assign baud_end = (baud_q == CW'(BAUD_DIV - 1));
  assign last_bit = baud_end && (bit_q == 4'(FRAME_BITS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= TX_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      TX_IDLE:         if (trmt) state_d = TX_TRANSMITTING;
      TX_TRANSMITTING: if (last_bit) state_d = TX_IDLE;
      default:         state_d = TX_IDLE;
    endcase
  end

  always_comb begin
    TX      = 1'b1;
    tx_done = done_q;
    if (state_q == TX_TRANSMITTING) TX = shift_q[0];
  end

  // Start bit sits in the LSB; ones shifted in from the top become the stop bit.
  always_comb begin
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    done_d  = done_q;
    case (state_q)
      TX_IDLE: begin
        if (trmt) begin
          shift_d = {tx_data, 1'b0};
          baud_d  = '0;
          bit_d   = '0;
          done_d  = 1'b0;
        end
      end
      TX_TRANSMITTING: begin
        if (baud_end) begin
          baud_d  = '0;
          shift_d = {1'b1, shift_q[8:1]};
          bit_d   = bit_q + 4'd1;
          if (last_bit) done_d = 1'b1;
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      done_q  <= 1'b0;
    end else begin
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: rtl/uart.sv
// rtl/uart.sv - UART top: independent transmitter and receiver
module uart
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       TX,
  output logic       tx_done,
  input  logic       RX,
  input  logic       clr_rdy,
  output logic [7:0] rx_data,
  output logic       rdy
);

  uart_tx #(.BAUD_DIV(BAUD_DIV)) u_tx (
    .clk     (clk),
    .rst_n   (rst_n),
    .trmt    (trmt),
    .tx_data (tx_data),
    .TX      (TX),
    .tx_done (tx_done)
  );

  uart_rx #(.BAUD_DIV(BAUD_DIV)) u_rx (
    .clk     (clk),
    .rst_n   (rst_n),
    .RX      (RX),
    .clr_rdy (clr_rdy),
    .rx_data (rx_data),
    .rdy     (rdy)
  );

endmodule

// File: tb/tb_uart.sv
// tb/tb_uart.sv - directed vector bench for uart in loopback and driven-RX modes
module tb_uart;

  localparam int B = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       trmt;
  logic [7:0] tx_data;
  logic       TX;
  logic       tx_done;
  logic       RX;
  logic       clr_rdy;
  logic [7:0] rx_data;
  logic       rdy;
  logic       lb;
  logic       rx_drv;

  int n_cmp = 0;
  int n_err = 0;

  assign RX = lb ? TX : rx_drv;

  always #5 clk = ~clk;

  uart #(.BAUD_DIV(B)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .trmt    (trmt),
    .tx_data (tx_data),
    .TX      (TX),
    .tx_done (tx_done),
    .RX      (RX),
    .clr_rdy (clr_rdy),
    .rx_data (rx_data),
    .rdy     (rdy)
  );

  typedef struct {
    logic [7:0] din;
    logic [7:0] inj;
    int         inj_at;
    logic [7:0] exp_rx;
    logic       b2b;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Starts a frame on the current negedge and returns on the negedge tx_done is seen.
  task automatic send_frame(input string tag, input logic [7:0] d, input int inj_at,
                            input logic [7:0] inj, output logic [9:0] bits,
                            output int lat, output logic done);
    int cyc;
    cyc  = 0;
    done = 1'b0;
    bits = '0;
    trmt = 1'b1;
    tx_data = d;
    while (!done && cyc < 10 * B + 40) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        chk({tag, "_done_clr"}, 32'(tx_done), 32'd0);
        tx_data = ~d;
      end
      trmt = (cyc == inj_at);
      if (cyc == inj_at) tx_data = inj;
      if (((cyc - 1) % B) == B / 2 && ((cyc - 1) / B) < 10) bits[(cyc - 1) / B] = TX;
      if (tx_done) done = 1'b1;
    end
    trmt = 1'b0;
    lat  = cyc;
  endtask

  task automatic rx_direct(input logic [9:0] bits, input logic hold_clr, output logic seen,
                           output logic [7:0] data, output int rise, output logic rdy_next);
    seen     = 1'b0;
    data     = '0;
    rise     = 0;
    rdy_next = 1'b1;
    clr_rdy  = hold_clr;
    rx_drv   = bits[0];
    for (int c = 1; c <= 11 * B; c++) begin
      @(negedge clk);
      if (rdy && !seen) begin
        seen = 1'b1;
        data = rx_data;
        rise = c;
      end else if (seen && c == rise + 1) begin
        rdy_next = rdy;
      end
      rx_drv = (c < 10 * B) ? bits[c / B] : 1'b1;
    end
    clr_rdy = 1'b0;
  endtask

  logic [9:0] bits;
  int         lat;
  logic       done;
  logic       ok5;
  logic       seen;
  logic [7:0] rdata;
  int         rise;
  logic       rdy_next;

  initial begin
    vecs[0] = '{din: 8'hAA, inj: 8'h00, inj_at: 0,     exp_rx: 8'hAA, b2b: 1'b0};
    vecs[1] = '{din: 8'h2B, inj: 8'h55, inj_at: 3 * B, exp_rx: 8'h2B, b2b: 1'b0};
    vecs[2] = '{din: 8'h00, inj: 8'h00, inj_at: 0,     exp_rx: 8'h00, b2b: 1'b0};
    vecs[3] = '{din: 8'hFF, inj: 8'h00, inj_at: 0,     exp_rx: 8'hFF, b2b: 1'b1};
    vecs[4] = '{din: 8'h96, inj: 8'h00, inj_at: 0,     exp_rx: 8'h96, b2b: 1'b0};

    rst_n = 1'b0; trmt = 1'b0; tx_data = '0; clr_rdy = 1'b0; lb = 1'b1; rx_drv = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(TX), 32'd1);
    chk("rst_tx_done", 32'(tx_done), 32'd0);
    chk("rst_rdy", 32'(rdy), 32'd0);
    chk("rst_rx_data", 32'(rx_data), 32'h00);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Loopback 0x2B, rdy hold, then clr_rdy.
    send_frame("f2B", 8'h2B, 0, 8'h00, bits, lat, done);
    chk("f2B_done_seen", 32'(done), 32'd1);
    chk("f2B_latency", 32'(lat), 32'(10 * B + 1));
    chk("f2B_tx_bits", 32'(bits), 32'({1'b1, 8'h2B, 1'b0}));
    chk("f2B_rx_data", 32'(rx_data), 32'h2B);
    chk("f2B_rdy", 32'(rdy), 32'd1);
    ok5 = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (!rdy) ok5 = 1'b0;
    end
    chk("f2B_rdy_hold5", 32'(ok5), 32'd1);
    clr_rdy = 1'b1;
    @(negedge clk);
    clr_rdy = 1'b0;
    chk("clr_rdy_low", 32'(rdy), 32'd0);
    chk("clr_rx_hold", 32'(rx_data), 32'h2B);

    for (int i = 0; i < 5; i++) begin
      if (vecs[i].b2b) chk($sformatf("v%0d_b2b_on_done", i), 32'(tx_done), 32'd1);
      else repeat (3) @(negedge clk);
      send_frame($sformatf("v%0d", i), vecs[i].din, vecs[i].inj_at, vecs[i].inj, bits, lat, done);
      chk($sformatf("v%0d_done_seen", i), 32'(done), 32'd1);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(10 * B + 1));
      chk($sformatf("v%0d_tx_bits", i), 32'(bits), 32'({1'b1, vecs[i].din, 1'b0}));
      chk($sformatf("v%0d_rx_data", i), 32'(rx_data), 32'(vecs[i].exp_rx));
      chk($sformatf("v%0d_rdy", i), 32'(rdy), 32'd1);
    end

    // Reset in the middle of a start bit.
    repeat (3) @(negedge clk);
    tx_data = 8'h5A;
    trmt = 1'b1;
    @(negedge clk);
    trmt = 1'b0;
    repeat (B / 2 - 1) @(negedge clk);
    chk("mid_tx_start", 32'(TX), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tx", 32'(TX), 32'd1);
    chk("mid_rst_tx_done", 32'(tx_done), 32'd0);
    chk("mid_rst_rdy", 32'(rdy), 32'd0);
    chk("mid_rst_rx_data", 32'(rx_data), 32'h00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_rdy", 32'(rdy), 32'd0);
    chk("post_rst_rx_data", 32'(rx_data), 32'h00);
    send_frame("fC3", 8'hC3, 0, 8'h00, bits, lat, done);
    chk("fC3_done_seen", 32'(done), 32'd1);
    chk("fC3_tx_bits", 32'(bits), 32'({1'b1, 8'hC3, 1'b0}));
    chk("fC3_rx_data", 32'(rx_data), 32'hC3);
    chk("fC3_rdy", 32'(rdy), 32'd1);

    // Bench-driven RX: clr_rdy held across the completing edge, then a low stop bit.
    repeat (3) @(negedge clk);
    lb = 1'b0;
    repeat (2) @(negedge clk);
    rx_direct({1'b1, 8'h3C, 1'b0}, 1'b1, seen, rdata, rise, rdy_next);
    chk("rxA_rdy_seen", 32'(seen), 32'd1);
    chk("rxA_data", 32'(rdata), 32'h3C);
    chk("rxA_rise_win", 32'(rise >= 9 * B + B / 2 + 1 && rise <= 9 * B + B / 2 + 4), 32'd1);
    chk("rxA_clr_after", 32'(rdy_next), 32'd0);
    repeat (2 * B) @(negedge clk);
    rx_direct({1'b0, 8'hA5, 1'b0}, 1'b0, seen, rdata, rise, rdy_next);
    chk("rxB_rdy_seen", 32'(seen), 32'd1);
    chk("rxB_data", 32'(rdata), 32'hA5);
    repeat (15 * B) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
